// File: rtl/si_coincidence_counter.sv
// Two-channel singles/coincidence counter over the si_tag_converter lane stream.
// Input register stage, then an in-order lane chain that updates history and gated accumulators.
module si_coincidence_counter #(
  parameter int unsigned WORD_WIDTH  = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [WORD_WIDTH-1:0]  s_axis_tkeep,
  input  logic [4:0]             s_axis_channel [WORD_WIDTH],
  input  logic [WORD_WIDTH-1:0]  s_axis_rising_edge,
  input  logic [63:0]            s_axis_tagtime [WORD_WIDTH],
  input  logic [4:0]             cfg_chan_a,
  input  logic [4:0]             cfg_chan_b,
  input  logic                   cfg_edge_a,
  input  logic                   cfg_edge_b,
  input  logic [31:0]            cfg_window,
  input  logic [31:0]            cfg_gate_cycles,
  input  logic                   cfg_restart,
  output logic [COUNT_WIDTH-1:0] singles_a,
  output logic [COUNT_WIDTH-1:0] singles_b,
  output logic [COUNT_WIDTH-1:0] coincidences,
  output logic                   snapshot_valid,
  output logic                   overflow
);

  localparam int unsigned TIME_W = 64;
  localparam int unsigned CHAN_W = 5;
  localparam int unsigned GATE_W = 32;
  // A lane can produce two coincidences (A step and B step), hence 2*WORD_WIDTH.
  localparam int unsigned INC_W  = $clog2(2 * WORD_WIDTH + 1);
  localparam int unsigned SUM_W  = COUNT_WIDTH + INC_W;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WORD_WIDTH-1:0] s1_keep;
  logic [CHAN_W-1:0]     s1_chan [WORD_WIDTH];
  logic [WORD_WIDTH-1:0] s1_edge;
  logic [TIME_W-1:0]     s1_time [WORD_WIDTH];
  logic                  s1_term;

  logic [GATE_W-1:0]     gate_cnt;
  logic                  term_c;

  logic [TIME_W-1:0]     last_a_time, last_b_time;
  logic                  last_a_vld, last_b_vld;
  logic [TIME_W-1:0]     nxt_a_time, nxt_b_time;
  logic                  nxt_a_vld, nxt_b_vld;
  logic [INC_W-1:0]      inc_a, inc_b, inc_c;

  logic [COUNT_WIDTH-1:0] acc_a, acc_b, acc_c;
  logic [COUNT_WIDTH-1:0] sum_a, sum_b, sum_c;
  logic                   sat_a, sat_b, sat_c;
  logic                   acc_ovf, nxt_ovf;

  assign term_c = (cfg_gate_cycles != '0) && (gate_cnt == cfg_gate_cycles - GATE_W'(1));

  always_ff @(posedge clk) begin
    if (rst) s_axis_tready <= 1'b0;
    else     s_axis_tready <= 1'b1;
  end

  // Input stage: the terminal-count flag travels with the beat accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || cfg_restart) begin
      s1_keep <= '0;
      s1_term <= 1'b0;
    end else begin
      s1_keep <= (s_axis_tvalid && s_axis_tready) ? s_axis_tkeep : '0;
      s1_term <= term_c;
    end
  end

  always_ff @(posedge clk) begin
    s1_chan <= s_axis_channel;
    s1_edge <= s_axis_rising_edge;
    s1_time <= s_axis_tagtime;
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_restart)             gate_cnt <= '0;
    else if (cfg_gate_cycles == '0 || term_c) gate_cnt <= '0;
    else                                gate_cnt <= gate_cnt + GATE_W'(1);
  end

  // Lane chain: each lane sees history already updated by lower lanes and by its own A step.
  always_comb begin
    nxt_a_time = last_a_time;
    nxt_a_vld  = last_a_vld;
    nxt_b_time = last_b_time;
    nxt_b_vld  = last_b_vld;
    inc_a      = '0;
    inc_b      = '0;
    inc_c      = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (s1_keep[i] && s1_chan[i] == cfg_chan_a && s1_edge[i] == cfg_edge_a) begin
        inc_a = inc_a + INC_W'(1);
        if (nxt_b_vld && (s1_time[i] - nxt_b_time) <= TIME_W'(cfg_window)) begin
          inc_c     = inc_c + INC_W'(1);
          nxt_b_vld = 1'b0;
        end else begin
          nxt_a_time = s1_time[i];
          nxt_a_vld  = 1'b1;
        end
      end
      if (s1_keep[i] && s1_chan[i] == cfg_chan_b && s1_edge[i] == cfg_edge_b) begin
        inc_b = inc_b + INC_W'(1);
        if (nxt_a_vld && (s1_time[i] - nxt_a_time) <= TIME_W'(cfg_window)) begin
          inc_c     = inc_c + INC_W'(1);
          nxt_a_vld = 1'b0;
        end else begin
          nxt_b_time = s1_time[i];
          nxt_b_vld  = 1'b1;
        end
      end
    end
  end

  // Saturating add; flags reaching the ceiling or pushing against it.
  function automatic logic [COUNT_WIDTH:0] sat_add(input logic [COUNT_WIDTH-1:0] acc,
                                                   input logic [INC_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    logic             hit;
    sum = SUM_W'(acc) + SUM_W'(inc);
    hit = (inc != '0) && (sum >= SUM_W'(CNT_MAX));
    if (sum > SUM_W'(CNT_MAX)) return {hit, CNT_MAX};
    return {hit, sum[COUNT_WIDTH-1:0]};
  endfunction

  always_comb begin
    {sat_a, sum_a} = sat_add(acc_a, inc_a);
    {sat_b, sum_b} = sat_add(acc_b, inc_b);
    {sat_c, sum_c} = sat_add(acc_c, inc_c);
    nxt_ovf        = acc_ovf | sat_a | sat_b | sat_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_a_time    <= '0;
      last_b_time    <= '0;
      last_a_vld     <= 1'b0;
      last_b_vld     <= 1'b0;
      acc_a          <= '0;
      acc_b          <= '0;
      acc_c          <= '0;
      acc_ovf        <= 1'b0;
      singles_a      <= '0;
      singles_b      <= '0;
      coincidences   <= '0;
      overflow       <= 1'b0;
      snapshot_valid <= 1'b0;
    end else if (cfg_restart) begin
      last_a_vld     <= 1'b0;
      last_b_vld     <= 1'b0;
      acc_a          <= '0;
      acc_b          <= '0;
      acc_c          <= '0;
      acc_ovf        <= 1'b0;
      snapshot_valid <= 1'b0;
    end else begin
      last_a_time    <= nxt_a_time;
      last_b_time    <= nxt_b_time;
      last_a_vld     <= nxt_a_vld;
      last_b_vld     <= nxt_b_vld;
      snapshot_valid <= s1_term;
      if (s1_term) begin
        singles_a    <= sum_a;
        singles_b    <= sum_b;
        coincidences <= sum_c;
        overflow     <= nxt_ovf;
        acc_a        <= '0;
        acc_b        <= '0;
        acc_c        <= '0;
        acc_ovf      <= 1'b0;
      end else begin
        acc_a        <= sum_a;
        acc_b        <= sum_b;
        acc_c        <= sum_c;
        acc_ovf      <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_si_coincidence_counter.sv
// Directed self-checking bench for si_coincidence_counter (4-bit counters to reach saturation).
module tb_si_coincidence_counter;

  localparam int unsigned WW = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [WW-1:0] s_axis_tkeep;
  logic [4:0]    s_axis_channel [WW];
  logic [WW-1:0] s_axis_rising_edge;
  logic [63:0]   s_axis_tagtime [WW];
  logic [4:0]    cfg_chan_a, cfg_chan_b;
  logic          cfg_edge_a, cfg_edge_b;
  logic [31:0]   cfg_window, cfg_gate_cycles;
  logic          cfg_restart;
  logic [CW-1:0] singles_a, singles_b, coincidences;
  logic          snapshot_valid, overflow;

  int checks = 0;
  int errors = 0;

  si_coincidence_counter #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_channel(s_axis_channel),
    .s_axis_rising_edge(s_axis_rising_edge), .s_axis_tagtime(s_axis_tagtime),
    .cfg_chan_a(cfg_chan_a), .cfg_chan_b(cfg_chan_b),
    .cfg_edge_a(cfg_edge_a), .cfg_edge_b(cfg_edge_b),
    .cfg_window(cfg_window), .cfg_gate_cycles(cfg_gate_cycles),
    .cfg_restart(cfg_restart),
    .singles_a(singles_a), .singles_b(singles_b), .coincidences(coincidences),
    .snapshot_valid(snapshot_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    cfg_restart = 1'b1;
    step();
    cfg_restart = 1'b0;
  endtask

  task automatic beat(input logic [1:0] k,
                      input logic [4:0] c0, input logic e0, input logic [63:0] t0,
                      input logic [4:0] c1, input logic e1, input logic [63:0] t1);
    s_axis_tvalid         = 1'b1;
    s_axis_tkeep          = k;
    s_axis_channel[0]     = c0;
    s_axis_channel[1]     = c1;
    s_axis_rising_edge    = {e1, e0};
    s_axis_tagtime[0]     = t0;
    s_axis_tagtime[1]     = t1;
    step();
    s_axis_tvalid         = 1'b0;
  endtask

  // One A tag per cycle on lane 0 with strictly increasing time.
  task automatic tick_tag();
    s_axis_tagtime[0] = s_axis_tagtime[0] + 64'd1000;
    step();
  endtask

  task automatic wait_snap(input string tag, input int max_cycles);
    int n = 0;
    while (!snapshot_valid && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_snap_seen"}, 64'(snapshot_valid), 64'd1);
  endtask

  task automatic expect_snap(input string tag, input int sa, input int sb, input int co, input int ov);
    wait_snap(tag, 70);
    check({tag, "_singles_a"}, 64'(singles_a), 64'(sa));
    check({tag, "_singles_b"}, 64'(singles_b), 64'(sb));
    check({tag, "_coinc"}, 64'(coincidences), 64'(co));
    check({tag, "_overflow"}, 64'(overflow), 64'(ov));
    step();
    check({tag, "_pulse_len"}, 64'(snapshot_valid), 64'd0);
  endtask

  initial begin
    int n;
    rst                = 1'b1;
    s_axis_tvalid      = 1'b0;
    s_axis_tkeep       = '0;
    s_axis_channel     = '{5'd0, 5'd0};
    s_axis_rising_edge = '0;
    s_axis_tagtime     = '{64'd0, 64'd0};
    cfg_chan_a         = 5'd1;
    cfg_chan_b         = 5'd2;
    cfg_edge_a         = 1'b1;
    cfg_edge_b         = 1'b1;
    cfg_window         = 32'd100;
    cfg_gate_cycles    = 32'd50;
    cfg_restart        = 1'b0;

    repeat (3) step();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_singles_a", 64'(singles_a), 64'd0);
    check("rst_coinc", 64'(coincidences), 64'd0);
    check("rst_snap_valid", 64'(snapshot_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    step();
    step();
    check("tready_after_rst", 64'(s_axis_tready), 64'd1);

    // Basic coincidence across separate beats
    restart();
    beat(2'b01, 5'd1, 1'b1, 64'd1000, 5'd0, 1'b0, 64'd0);
    beat(2'b01, 5'd2, 1'b1, 64'd1080, 5'd0, 1'b0, 64'd0);
    expect_snap("basic", 1, 1, 1, 0);

    // Window is inclusive
    restart();
    beat(2'b01, 5'd1, 1'b1, 64'd0, 5'd0, 1'b0, 64'd0);
    beat(2'b01, 5'd2, 1'b1, 64'd100, 5'd0, 1'b0, 64'd0);
    expect_snap("win_100", 1, 1, 1, 0);
    restart();
    beat(2'b01, 5'd1, 1'b1, 64'd0, 5'd0, 1'b0, 64'd0);
    beat(2'b01, 5'd2, 1'b1, 64'd101, 5'd0, 1'b0, 64'd0);
    expect_snap("win_101", 1, 1, 0, 0);

    // Same-beat lanes, then lane 1 masked off
    restart();
    beat(2'b11, 5'd2, 1'b1, 64'd500, 5'd1, 1'b1, 64'd500);
    expect_snap("same_beat", 1, 1, 1, 0);
    restart();
    beat(2'b01, 5'd2, 1'b1, 64'd500, 5'd1, 1'b1, 64'd500);
    expect_snap("lane1_nokeep", 0, 1, 0, 0);

    // Pair consumption and falling-edge filter
    restart();
    beat(2'b01, 5'd1, 1'b1, 64'd0, 5'd0, 1'b0, 64'd0);
    beat(2'b01, 5'd2, 1'b1, 64'd10, 5'd0, 1'b0, 64'd0);
    beat(2'b01, 5'd1, 1'b1, 64'd20, 5'd0, 1'b0, 64'd0);
    beat(2'b01, 5'd1, 1'b0, 64'd30, 5'd0, 1'b0, 64'd0);
    expect_snap("pair_consume", 2, 1, 1, 0);

    // Gate of 4 with one A tag every cycle
    cfg_gate_cycles       = 32'd4;
    restart();
    s_axis_tvalid         = 1'b1;
    s_axis_tkeep          = 2'b01;
    s_axis_channel[0]     = 5'd1;
    s_axis_rising_edge    = 2'b01;
    s_axis_tagtime[0]     = 64'd100000;
    n = 0;
    while (!snapshot_valid && n < 20) begin
      tick_tag();
      n++;
    end
    check("gate_first_snap", 64'(snapshot_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick_tag();
        n++;
      end while (!snapshot_valid && n < 10);
      check("gate_period", 64'(n), 64'd4);
      check("gate_singles_a", 64'(singles_a), 64'd4);
    end
    // Restart lands on the next terminal count (two cycles after the pulse)
    tick_tag();
    tick_tag();
    cfg_restart = 1'b1;
    tick_tag();
    cfg_restart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("rst_tc_no_snap", 64'(snapshot_valid), 64'd0);
      tick_tag();
    end
    check("rst_tc_snap_after", 64'(snapshot_valid), 64'd1);
    check("rst_tc_singles_a", 64'(singles_a), 64'd4);
    s_axis_tvalid = 1'b0;

    // Saturation with snapshots disabled, then gated readout
    cfg_gate_cycles = 32'd0;
    restart();
    s_axis_tvalid = 1'b1;
    repeat (20) tick_tag();
    s_axis_tvalid = 1'b0;
    repeat (3) step();
    check("gate0_no_snap", 64'(snapshot_valid), 64'd0);
    cfg_gate_cycles = 32'd30;
    expect_snap("saturate", 15, 0, 0, 1);
    expect_snap("after_sat", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
